axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter ID_WIDTH, default 4, AXI ID width on all channels.
REQ-002 Parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 Parameter MEM_WORDS_LOG2, default 10, log2 of memory depth in 32-bit words (1024 words).
REQ-004 aclk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 aresetn  input  1  asynchronous, active-low reset.
REQ-006 AW channel  s_axi_awid[ID_WIDTH] awaddr[ADDR_WIDTH] awlen[8] awburst[2] awvalid in; awready out.
REQ-007 W channel  s_axi_wdata[32] wstrb[4] wlast wvalid in; wready out.
REQ-008 B channel  s_axi_bid[ID_WIDTH] bresp[2] bvalid out; bready in.
REQ-009 AR channel  s_axi_arid[ID_WIDTH] araddr[ADDR_WIDTH] arlen[8] arburst[2] arvalid in; arready out.
REQ-010 R channel  s_axi_rid[ID_WIDTH] rdata[32] rresp[2] rlast rvalid out; rready in.

Function
REQ-011 The block SHALL be the AXI4 slave memory downstream of the chip interconnect; data width fixed 32 bits, size fixed 4 bytes, one outstanding write and one outstanding read, channels independent.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-013 W_IDLE->W_DATA on AW handshake, capturing awid, word address awaddr[ADDR_WIDTH-1:2], awlen, awburst; beat counter cleared.
REQ-014 Each W handshake SHALL write enabled bytes (wstrb) to mem[addr] in that cycle; addr +1 per beat for INCR (01) or WRAP (10, treated as INCR), unchanged for FIXED (00).
REQ-015 W_DATA->W_RESP on handshake of beat number awlen (awlen+1 beats); wlast SHALL be ignored for control; no further W accepted.
REQ-016 W_RESP holds bid/bresp stable until bready; W_RESP->W_IDLE on B handshake; next AW accepted earliest the following cycle.
REQ-017 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; rvalid=1 only in R_DATA.
REQ-018 AR handshake in cycle N SHALL give first rvalid in cycle N+1; memory read is combinational (distributed RAM) so beats issue back-to-back while rready=1.
REQ-019 rid, rdata, rresp, rlast SHALL be held stable while rvalid=1 and rready=0; rlast=1 exactly on beat arlen; R_DATA->R_IDLE on last R handshake.
REQ-020 Address increment SHALL wrap modulo 2^(ADDR_WIDTH-2) words; beat counters 8 bits.
REQ-021 Same-cycle write and read of one word: read returns old data; writes complete in earlier cycles are visible.
REQ-022 Response codes: OKAY (00) unless REQ-027 applies.

Reset
REQ-023 While aresetn=0: both FSMs idle, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid/rid/rdata/bresp/rresp=0.
REQ-024 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL NOT be cleared by reset.
REQ-025 Release of aresetn SHALL take effect on the first aclk rising edge after deassertion; no handshake completes in that edge's cycle.

Configuration
REQ-026 Macro AXI_MEM_SLVERR_EN selects out-of-range handling; a beat is out-of-range when word address >= 2^MEM_WORDS_LOG2.
REQ-027 With AXI_MEM_SLVERR_EN defined: out-of-range write beats dropped and bresp=SLVERR (10) if any beat was out-of-range; out-of-range read beats return rdata=0, rresp=SLVERR per beat.
REQ-028 Without AXI_MEM_SLVERR_EN: memory index = word address modulo 2^MEM_WORDS_LOG2, all responses OKAY.

Verification
REQ-029 AW id=3 addr=0x0010 len=3 INCR, W 0xA0..0xA3 strb=F -> bid=3 bresp=00; AR same -> 4 beats 0xA0..0xA3, rlast on beat 4 only.
REQ-030 Write 0xFFFFFFFF to 0x0020 then wstrb=0101 data 0x11223344 -> read 0x0020 returns 0xFF22FF44.
REQ-031 FIXED len=2 to 0x0040 data 1,2,3 -> read 0x0040 returns 3; 0x0044 unchanged.
REQ-032 Read len=1 with rready low 5 cycles -> rvalid/rdata/rid stable throughout, completes after rready high.
REQ-033 Write to 0x1000 (word 1024): macro defined -> bresp=10, read rresp=10 rdata=0; undefined -> word 0 overwritten, OKAY.
REQ-034 aresetn pulsed low during beat 2 of len=7 write -> no bvalid, awready=1 after reset, earlier written beats retained.

Source files
------------

// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_slave
// Description : AXI4 slave memory, 32-bit data, fixed 4-byte beats. One
//               outstanding write and one outstanding read, with independent
//               write and read channel state machines. The storage is a
//               distributed RAM: it is read combinationally and written
//               through byte strobes on the rising clock edge.
// Ports       : aclk, aresetn (asynchronous, active low)
//               AW : s_axi_awid/awaddr/awlen/awburst/awvalid -> awready
//               W  : s_axi_wdata/wstrb/wlast/wvalid          -> wready
//               B  : bid/bresp/bvalid                        <- bready
//               AR : s_axi_arid/araddr/arlen/arburst/arvalid -> arready
//               R  : rid/rdata/rresp/rlast/rvalid            <- rready
// Options     : AXI_MEM_SLVERR_EN -- when defined, beats beyond the memory
//               depth give SLVERR (writes dropped, reads return zero).
//               When undefined, the address is taken modulo the depth.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_slave #(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // write address
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int         WA_W        = ADDR_WIDTH - 2;
    localparam int         MEM_WORDS   = 1 << MEM_WORDS_LOG2;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // Storage is deliberately not reset: contents survive aresetn.
    logic [31:0] mem_q [MEM_WORDS];

    // Low for the first edge after reset release so that edge cannot
    // complete any handshake even though the ready outputs are already high.
    logic live_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_e           wstate_q, wstate_d;
    logic [ID_WIDTH-1:0] awid_q, awid_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [7:0]        awlen_q, awlen_d;
    logic              wfixed_q, wfixed_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              werr_q, werr_d;
    logic              w_wr_oor;
    logic              w_wr_drop;
    logic              w_we;

`ifdef AXI_MEM_SLVERR_EN
    assign w_wr_drop = w_wr_oor;
`else
    assign w_wr_drop = 1'b0;
`endif

    always_comb begin
        wstate_d      = wstate_q;
        awid_d        = awid_q;
        waddr_d       = waddr_q;
        awlen_d       = awlen_q;
        wfixed_d      = wfixed_q;
        wcnt_d        = wcnt_q;
        werr_d        = werr_q;
        w_we          = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid && live_q) begin
                    awid_d    = s_axi_awid;
                    waddr_d   = s_axi_awaddr[ADDR_WIDTH-1:2];
                    awlen_d   = s_axi_awlen;
                    wfixed_d  = (s_axi_awburst == BURST_FIXED);
                    wcnt_d    = 8'd0;
                    werr_d    = 1'b0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    w_we = !w_wr_drop;
                    if (w_wr_drop) begin
                        werr_d = 1'b1;
                    end
                    // WRAP is handled as INCR; the word address rolls over
                    // naturally at the top of the address space.
                    if (!wfixed_q) begin
                        waddr_d = waddr_q + 1'b1;
                    end
                    wcnt_d = wcnt_q + 8'd1;
                    // Burst length comes from awlen alone; wlast is ignored.
                    if (wcnt_q == awlen_q) begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q <= W_IDLE;
            awid_q   <= '0;
            waddr_q  <= '0;
            awlen_q  <= '0;
            wfixed_q <= 1'b0;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            awid_q   <= awid_d;
            waddr_q  <= waddr_d;
            awlen_q  <= awlen_d;
            wfixed_q <= wfixed_d;
            wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;
        end
    end

    assign s_axi_bid   = awid_q;
    assign s_axi_bresp = werr_q ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[waddr_q[MEM_WORDS_LOG2-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_e           rstate_q, rstate_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [WA_W-1:0]   raddr_q, raddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              rfixed_q, rfixed_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [WA_W-1:0]   w_raddr_next;
    logic [WA_W-1:0]   w_rd_addr;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_rd_data;
    logic [1:0]        w_rd_resp;
    logic              w_rd_oor;

    assign w_raddr_next = rfixed_q ? raddr_q : raddr_q + 1'b1;
    // In idle the only load is the first beat at the AR handshake; in the
    // data state the only load is the following beat at an R handshake.
    assign w_rd_addr    = (rstate_q == R_IDLE) ? s_axi_araddr[ADDR_WIDTH-1:2] : w_raddr_next;
    assign w_rd_word    = mem_q[w_rd_addr[MEM_WORDS_LOG2-1:0]];

`ifdef AXI_MEM_SLVERR_EN
    assign w_rd_data = w_rd_oor ? 32'd0 : w_rd_word;
    assign w_rd_resp = w_rd_oor ? RESP_SLVERR : RESP_OKAY;
`else
    assign w_rd_data = w_rd_word;
    assign w_rd_resp = RESP_OKAY;
`endif

    generate
        if (WA_W > MEM_WORDS_LOG2) begin : g_oor
            assign w_wr_oor = |waddr_q[WA_W-1:MEM_WORDS_LOG2];
            assign w_rd_oor = |w_rd_addr[WA_W-1:MEM_WORDS_LOG2];
        end else begin : g_no_oor
            assign w_wr_oor = 1'b0;
            assign w_rd_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        rstate_d      = rstate_q;
        rid_d         = rid_q;
        raddr_d       = raddr_q;
        arlen_d       = arlen_q;
        rfixed_d      = rfixed_q;
        rcnt_d        = rcnt_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid && live_q) begin
                    rid_d    = s_axi_arid;
                    raddr_d  = s_axi_araddr[ADDR_WIDTH-1:2];
                    arlen_d  = s_axi_arlen;
                    rfixed_d = (s_axi_arburst == BURST_FIXED);
                    rcnt_d   = 8'd0;
                    rdata_d  = w_rd_data;
                    rresp_d  = w_rd_resp;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = (rcnt_q == arlen_q);
                if (s_axi_rready) begin
                    if (rcnt_q == arlen_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        raddr_d = w_raddr_next;
                        rdata_d = w_rd_data;
                        rresp_d = w_rd_resp;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            raddr_q  <= '0;
            arlen_q  <= '0;
            rfixed_q <= 1'b0;
            rcnt_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            arlen_q  <= arlen_d;
            rfixed_q <= rfixed_d;
            rcnt_q   <= rcnt_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign s_axi_rid   = rid_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;

    // Byte-offset address bits and wlast carry no information for this slave.
    logic w_unused_ok;
    assign w_unused_ok = ^{s_axi_wlast, s_axi_awaddr[1:0], s_axi_araddr[1:0], w_wr_oor, w_rd_oor};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
module tb_axi_mem_slave;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  s_axi_awid;
    logic [15:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [15:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fails  = 0;

    // stimulus and scoreboard
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    logic [33:0] exp_q[$];      // {rresp, rdata}
    // observed read beats
    logic [31:0] od_q[$];
    logic [1:0]  or_q[$];
    logic        ol_q[$];
    logic [3:0]  oid_q[$];
    logic [37:0] stall_q[$];    // {rvalid, rid, rdata, rlast} during rready=0

    axi_mem_slave dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    function automatic logic hs_sig(input int sel);
        case (sel)
            0:       return s_axi_awready;
            1:       return s_axi_wready;
            2:       return s_axi_bvalid;
            3:       return s_axi_arready;
            default: return s_axi_rvalid;
        endcase
    endfunction

    // Waits (sampling on negedge) until the selected ready/valid is high;
    // the handshake then completes on the following posedge.
    task automatic wait_hs(input int sel, input string nm);
        int t;
        t = 0;
        forever begin
            @(negedge aclk);
            if (hs_sig(sel)) break;
            t++;
            if (t > 64) begin
                n_checks++;
                n_fails++;
                $display("FAIL %s_timeout: handshake signal still 0 after %0d cycles, required 1 within 64", nm, t);
                break;
            end
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, output logic [3:0] bid, output logic [1:0] bresp);
        @(posedge aclk); #1;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        wait_hs(0, "aw");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata  = wd_q.pop_front();
            s_axi_wstrb  = ws_q.pop_front();
            s_axi_wlast  = (i == int'(len));
            s_axi_wvalid = 1'b1;
            wait_hs(1, "w");
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        s_axi_bready = 1'b1;
        wait_hs(2, "b");
        bid   = s_axi_bid;
        bresp = s_axi_bresp;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    // ncyc counts negedges from rready high up to and including the last beat.
    task automatic axi_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall, output int ncyc);
        int got;
        od_q.delete(); or_q.delete(); ol_q.delete(); oid_q.delete(); stall_q.delete();
        @(posedge aclk); #1;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        wait_hs(3, "ar");
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            stall_q.push_back({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rlast});
        end
        if (stall > 0) begin
            @(posedge aclk); #1;
        end
        s_axi_rready = 1'b1;
        ncyc = 0;
        got  = 0;
        while (got <= int'(len) && ncyc < int'(len) + 64) begin
            @(negedge aclk);
            ncyc++;
            if (s_axi_rvalid) begin
                od_q.push_back(s_axi_rdata);
                or_q.push_back(s_axi_rresp);
                ol_q.push_back(s_axi_rlast);
                oid_q.push_back(s_axi_rid);
                got++;
            end
        end
        if (got <= int'(len)) begin
            n_checks++;
            n_fails++;
            $display("FAIL r_timeout: got %0d beats, required %0d", got, int'(len) + 1);
            while (got <= int'(len)) begin
                od_q.push_back('x); or_q.push_back('x); ol_q.push_back(1'bx); oid_q.push_back('x);
                got++;
            end
        end
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 6'b110000) begin
            n_fails++;
            $display("FAIL reset_ctl: {awr,arr,wr,bv,rv,rl}=%b, required 110000",
                     {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast});
        end
        n_checks++;
        if ({s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 44'd0) begin
            n_fails++;
            $display("FAIL reset_data: bid=%h rid=%h bresp=%b rresp=%b rdata=%h, required all 0",
                     s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp, s_axi_rdata);
        end
        // AW offered in the release cycle must not be accepted on that edge.
        aresetn       = 1'b1;
        s_axi_awid    = 4'd9;
        s_axi_awaddr  = 16'h0000;
        s_axi_awlen   = 8'd0;
        s_axi_awburst = INCR;
        s_axi_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        @(negedge aclk);
        n_checks++;
        if ({s_axi_awready, s_axi_wready} !== 2'b10) begin
            n_fails++;
            $display("FAIL release_edge: {awready,wready}=%b, required 10", {s_axi_awready, s_axi_wready});
        end
    endtask

    task automatic test_incr_burst();
        logic [3:0] bid; logic [1:0] br; int ncyc; logic [33:0] e;
        for (int i = 0; i < 4; i++) begin
            wd_q.push_back(32'hA0 + i);
            ws_q.push_back(4'hF);
            exp_q.push_back({2'b00, 32'hA0 + 32'(i)});
        end
        axi_write(4'd3, 16'h0010, 8'd3, INCR, bid, br);
        n_checks++;
        if ({bid, br} !== {4'd3, 2'b00}) begin
            n_fails++;
            $display("FAIL incr_b: bid=%h bresp=%b, required bid=3 bresp=00", bid, br);
        end
        axi_read(4'd3, 16'h0010, 8'd3, INCR, 0, ncyc);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({or_q[i], od_q[i], oid_q[i], ol_q[i]} !== {e, 4'd3, (i == 3)}) begin
                n_fails++;
                $display("FAIL incr_r beat%0d: resp=%b data=%h id=%h last=%b, required resp=%b data=%h id=3 last=%b",
                         i, or_q[i], od_q[i], oid_q[i], ol_q[i], e[33:32], e[31:0], (i == 3));
            end
        end
        n_checks++;
        if (ncyc !== 4) begin
            n_fails++;
            $display("FAIL incr_latency: burst took %0d cycles, required 4", ncyc);
        end
    endtask

    task automatic test_strobe();
        logic [3:0] bid; logic [1:0] br; int ncyc; logic [33:0] e;
        wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'hF);
        axi_write(4'd1, 16'h0020, 8'd0, INCR, bid, br);
        wd_q.push_back(32'h1122_3344); ws_q.push_back(4'b0101);
        axi_write(4'd2, 16'h0020, 8'd0, INCR, bid, br);
        n_checks++;
        if ({bid, br} !== {4'd2, 2'b00}) begin
            n_fails++;
            $display("FAIL strobe_b: bid=%h bresp=%b, required bid=2 bresp=00", bid, br);
        end
        exp_q.push_back({2'b00, 32'hFF22_FF44});
        axi_read(4'd4, 16'h0020, 8'd0, INCR, 0, ncyc);
        e = exp_q.pop_front();
        n_checks++;
        if ({or_q[0], od_q[0]} !== e) begin
            n_fails++;
            $display("FAIL strobe_r: resp=%b data=%h, required resp=%b data=%h", or_q[0], od_q[0], e[33:32], e[31:0]);
        end
    endtask

    task automatic test_fixed();
        logic [3:0] bid; logic [1:0] br; int ncyc; logic [33:0] e;
        wd_q.push_back(32'hCAFE_F00D); ws_q.push_back(4'hF);
        axi_write(4'd1, 16'h0044, 8'd0, INCR, bid, br);
        for (int i = 1; i <= 3; i++) begin
            wd_q.push_back(32'(i)); ws_q.push_back(4'hF);
        end
        axi_write(4'd6, 16'h0040, 8'd2, FIXED, bid, br);
        n_checks++;
        if ({bid, br} !== {4'd6, 2'b00}) begin
            n_fails++;
            $display("FAIL fixed_b: bid=%h bresp=%b, required bid=6 bresp=00", bid, br);
        end
        exp_q.push_back({2'b00, 32'd3});
        exp_q.push_back({2'b00, 32'hCAFE_F00D});
        axi_read(4'd2, 16'h0040, 8'd1, INCR, 0, ncyc);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({or_q[i], od_q[i]} !== e) begin
                n_fails++;
                $display("FAIL fixed_r beat%0d: resp=%b data=%h, required resp=%b data=%h",
                         i, or_q[i], od_q[i], e[33:32], e[31:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] bid; logic [1:0] br; int ncyc; logic [33:0] e;
        wd_q.push_back(32'h1111_0000); ws_q.push_back(4'hF);
        wd_q.push_back(32'h2222_0001); ws_q.push_back(4'hF);
        axi_write(4'd0, 16'h0200, 8'd1, INCR, bid, br);
        exp_q.push_back({2'b00, 32'h1111_0000});
        exp_q.push_back({2'b00, 32'h2222_0001});
        axi_read(4'd5, 16'h0200, 8'd1, INCR, 5, ncyc);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (stall_q[i] !== {1'b1, 4'd5, 32'h1111_0000, 1'b0}) begin
                n_fails++;
                $display("FAIL stall cycle%0d: {rvalid,rid,rdata,rlast}=%h, required %h",
                         i, stall_q[i], {1'b1, 4'd5, 32'h1111_0000, 1'b0});
            end
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({or_q[i], od_q[i], oid_q[i], ol_q[i]} !== {e, 4'd5, (i == 1)}) begin
                n_fails++;
                $display("FAIL stall_r beat%0d: resp=%b data=%h id=%h last=%b, required resp=%b data=%h id=5 last=%b",
                         i, or_q[i], od_q[i], oid_q[i], ol_q[i], e[33:32], e[31:0], (i == 1));
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] bid; logic [1:0] br; int ncyc; logic [33:0] e;
        logic [1:0] exp_b;
        wd_q.push_back(32'h1234_5678); ws_q.push_back(4'hF);
        axi_write(4'd1, 16'h0000, 8'd0, INCR, bid, br);
        wd_q.push_back(32'hDEAD_BEEF); ws_q.push_back(4'hF);
        axi_write(4'd8, 16'h1000, 8'd0, INCR, bid, br);
`ifdef AXI_MEM_SLVERR_EN
        exp_b = 2'b10;
        exp_q.push_back({2'b10, 32'd0});
        exp_q.push_back({2'b00, 32'h1234_5678});
`else
        exp_b = 2'b00;
        exp_q.push_back({2'b00, 32'hDEAD_BEEF});
        exp_q.push_back({2'b00, 32'hDEAD_BEEF});
`endif
        n_checks++;
        if ({bid, br} !== {4'd8, exp_b}) begin
            n_fails++;
            $display("FAIL oor_b: bid=%h bresp=%b, required bid=8 bresp=%b", bid, br, exp_b);
        end
        for (int k = 0; k < 2; k++) begin
            axi_read(4'd3, (k == 0) ? 16'h1000 : 16'h0000, 8'd0, INCR, 0, ncyc);
            e = exp_q.pop_front();
            n_checks++;
            if ({or_q[0], od_q[0]} !== e) begin
                n_fails++;
                $display("FAIL oor_r read%0d: resp=%b data=%h, required resp=%b data=%h",
                         k, or_q[0], od_q[0], e[33:32], e[31:0]);
            end
        end
        // Burst straddling the top of memory: only the second beat is out of range.
        wd_q.push_back(32'h0BAD_0001); ws_q.push_back(4'hF);
        wd_q.push_back(32'h0BAD_0002); ws_q.push_back(4'hF);
        axi_write(4'd9, 16'h0FFC, 8'd1, INCR, bid, br);
        n_checks++;
        if ({bid, br} !== {4'd9, exp_b}) begin
            n_fails++;
            $display("FAIL straddle_b: bid=%h bresp=%b, required bid=9 bresp=%b", bid, br, exp_b);
        end
        exp_q.push_back({2'b00, 32'h0BAD_0001});
`ifdef AXI_MEM_SLVERR_EN
        exp_q.push_back({2'b10, 32'd0});
`else
        exp_q.push_back({2'b00, 32'h0BAD_0002});
`endif
        axi_read(4'd3, 16'h0FFC, 8'd1, INCR, 0, ncyc);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({or_q[i], od_q[i]} !== e) begin
                n_fails++;
                $display("FAIL straddle_r beat%0d: resp=%b data=%h, required resp=%b data=%h",
                         i, or_q[i], od_q[i], e[33:32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] bid; logic [1:0] br; int ncyc; logic [33:0] e; logic bv_seen;
        wd_q.push_back(32'h5555_5555); ws_q.push_back(4'hF);
        axi_write(4'd2, 16'h0108, 8'd0, INCR, bid, br);
        @(posedge aclk); #1;
        s_axi_awid    = 4'd7;
        s_axi_awaddr  = 16'h0100;
        s_axi_awlen   = 8'd7;
        s_axi_awburst = INCR;
        s_axi_awvalid = 1'b1;
        wait_hs(0, "aw");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_axi_wdata  = 32'hB0 + i;
            s_axi_wstrb  = 4'hF;
            s_axi_wvalid = 1'b1;
            wait_hs(1, "w");
            @(posedge aclk); #1;
        end
        s_axi_wdata  = 32'hB2;
        s_axi_wvalid = 1'b1;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b010) begin
            n_fails++;
            $display("FAIL midrst_in_reset: {bvalid,awready,wready}=%b, required 010",
                     {s_axi_bvalid, s_axi_awready, s_axi_wready});
        end
        s_axi_wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        bv_seen = 1'b0;
        repeat (4) begin
            @(negedge aclk);
            bv_seen = bv_seen | s_axi_bvalid;
        end
        n_checks++;
        if ({bv_seen, s_axi_awready} !== 2'b01) begin
            n_fails++;
            $display("FAIL midrst_after: {bvalid_seen,awready}=%b, required 01", {bv_seen, s_axi_awready});
        end
        exp_q.push_back({2'b00, 32'hB0});
        exp_q.push_back({2'b00, 32'hB1});
        exp_q.push_back({2'b00, 32'h5555_5555});
        axi_read(4'd1, 16'h0100, 8'd2, INCR, 0, ncyc);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({or_q[i], od_q[i]} !== e) begin
                n_fails++;
                $display("FAIL midrst_r beat%0d: resp=%b data=%h, required resp=%b data=%h",
                         i, or_q[i], od_q[i], e[33:32], e[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] bid; logic [1:0] br; int ncyc; logic [33:0] e; logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            d = $urandom();
            wd_q.push_back(d); ws_q.push_back(4'hF);
            exp_q.push_back({2'b00, d});
        end
        axi_write(4'd12, 16'h0300, 8'd15, INCR, bid, br);
        n_checks++;
        if ({bid, br} !== {4'd12, 2'b00}) begin
            n_fails++;
            $display("FAIL b2b_b: bid=%h bresp=%b, required bid=c bresp=00", bid, br);
        end
        axi_read(4'd13, 16'h0300, 8'd15, INCR, 0, ncyc);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({or_q[i], od_q[i], oid_q[i], ol_q[i]} !== {e, 4'd13, (i == 15)}) begin
                n_fails++;
                $display("FAIL b2b_r beat%0d: resp=%b data=%h id=%h last=%b, required resp=%b data=%h id=d last=%b",
                         i, or_q[i], od_q[i], oid_q[i], ol_q[i], e[33:32], e[31:0], (i == 15));
            end
        end
        n_checks++;
        if (ncyc !== 16) begin
            n_fails++;
            $display("FAIL b2b_latency: burst took %0d cycles, required 16", ncyc);
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;

        test_reset();
        test_incr_burst();
        test_strobe();
        test_fixed();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_burst();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
